// File: rtl/pcie_mwr_pattern_gen_if.sv
// Avalon-ST 256-bit TX bundle between the MWr generator and the TX arbiter.
interface pcie_mwr_pattern_gen_if;
    logic [255:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_sop;
    logic         tx_eop;
    logic [1:0]   tx_empty;

    modport master (
        output tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
        input  tx_ready
    );
    modport slave (
        input  tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
        output tx_ready
    );
endinterface

// File: rtl/pcie_mwr_pattern_gen.sv
// PCIe MWr DMA engine: 16-bit incrementing payload, 3DW/4DW headers, 4 KB split.
// Defining PCIE_MWR_GEN_STATS_EN builds the TLP and stall counters.
module pcie_mwr_pattern_gen #(
    parameter int unsigned MAX_PAYLOAD  = 256,
    parameter logic [15:0] REQ_ID       = 16'h0000,
    parameter logic [15:0] PATTERN_INIT = 16'h0000,
    parameter int unsigned MAX_LEN_W    = 24
) (
    input  logic                 coreclkout_hip,
    input  logic                 reset_status,
    input  logic [63:0]          cfg_addr,
    input  logic [MAX_LEN_W-1:0] cfg_len,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    pcie_mwr_pattern_gen_if.master tx,
    output logic [31:0]          tlp_count,
    output logic [31:0]          stall_count
);
    typedef enum logic [2:0] {IDLE, CALC, HDR, DATA, NEXT} state_t;

    state_t               state_q, state_d;
    logic [63:0]          addr_q, addr_d;
    logic [MAX_LEN_W-1:0] rem_q, rem_d;
    logic [12:0]          n_q, n_d;
    logic [12:0]          tlp_rem_q, tlp_rem_d;
    logic [7:0]           tag_q, tag_d;
    logic [15:0]          pat_q, pat_d;
    logic                 abort_q, abort_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [255:0]         data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic [1:0]           empty_q, empty_d;

    logic         accept, is4, beat_last;
    logic         start_bad, load_data;
    logic [12:0]  bound, cap, n_calc;
    logic [255:0] pat_beat;
    logic [127:0] hdr;

    always_comb begin
        pat_beat = '0;
        for (int i = 0; i < 16; i++)
            pat_beat[i*16 +: 16] = pat_q + 16'(i);
    end

    assign accept = valid_q && tx.tx_ready;
    assign bound  = 13'd4096 - {1'b0, addr_q[11:0]};
    assign cap    = (rem_q > MAX_LEN_W'(MAX_PAYLOAD))
                  ? 13'(MAX_PAYLOAD) : 13'(rem_q);
    assign n_calc = (cap < bound) ? cap : bound;

    // Length is n/4 in 10 bits, so 1024 DW naturally encodes as 0
    assign is4          = |addr_q[63:32];
    assign hdr[31:0]    = {2'b01, is4, 5'd0, 14'd0, n_q[11:2]};
    assign hdr[63:32]   = {REQ_ID, tag_q, 8'hFF};
    assign hdr[95:64]   = is4 ? addr_q[63:32]
                              : {addr_q[31:2], 2'b00};
    assign hdr[127:96]  = is4 ? addr_q[31:0] : 32'd0;

    assign beat_last = tlp_rem_q <= 13'd32;
    assign start_bad = (cfg_len == '0) || (|cfg_len[3:0])
                    || (|cfg_addr[3:0]);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        n_d       = n_q;
        tlp_rem_d = tlp_rem_q;
        tag_d     = tag_q;
        pat_d     = pat_q;
        err_d     = err_q;
        done_d    = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        empty_d   = empty_q;
        load_data = 1'b0;
        abort_d   = abort_q | (cfg_abort && state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (start_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = cfg_addr;
                        rem_d   = cfg_len;
                        pat_d   = PATTERN_INIT;
                        abort_d = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                n_d = n_calc;
                if (abort_d) begin
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!valid_q) begin
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = (n_q == 13'd16);
                    empty_d   = 2'd0;
                    data_d    = {pat_beat[127:0], hdr};
                    pat_d     = pat_q + 16'd8;
                    tlp_rem_d = n_q - 13'd16;
                end else if (accept) begin
                    if (eop_q) begin
                        state_d = NEXT;
                    end else begin
                        load_data = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (eop_q) state_d = NEXT;
                    else       load_data = 1'b1;
                end
            end
            NEXT: begin
                addr_d = addr_q + 64'(n_q);
                rem_d  = rem_q - MAX_LEN_W'(n_q);
                tag_d  = tag_q + 8'd1;
                if (rem_d == '0 || abort_d) begin
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept && eop_q) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = 2'd0;
        end
        // A trailing half beat carries 8 words and reports two empty qwords
        if (load_data) begin
            valid_d   = 1'b1;
            sop_d     = 1'b0;
            eop_d     = beat_last;
            empty_d   = (tlp_rem_q == 13'd16) ? 2'd2 : 2'd0;
            data_d    = pat_beat;
            pat_d     = pat_q + ((tlp_rem_q == 13'd16)
                      ? 16'd8 : 16'd16);
            tlp_rem_d = beat_last ? 13'd0
                      : tlp_rem_q - 13'd32;
        end
    end

    always_ff @(posedge coreclkout_hip or posedge reset_status) begin
        if (reset_status) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            n_q       <= '0;
            tlp_rem_q <= '0;
            tag_q     <= '0;
            pat_q     <= PATTERN_INIT;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            empty_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            n_q       <= n_d;
            tlp_rem_q <= tlp_rem_d;
            tag_q     <= tag_d;
            pat_q     <= pat_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            empty_q   <= empty_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_sop   = sop_q;
    assign tx.tx_eop   = eop_q;
    assign tx.tx_empty = empty_q;

`ifdef PCIE_MWR_GEN_STATS_EN
    logic [31:0] tlp_cnt_q, tlp_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        tlp_cnt_d   = tlp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && eop_q && tlp_cnt_q != '1)
            tlp_cnt_d = tlp_cnt_q + 32'd1;
        if (valid_q && !tx.tx_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge coreclkout_hip or posedge reset_status) begin
        if (reset_status) begin
            tlp_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            tlp_cnt_q   <= tlp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign tlp_count   = tlp_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign tlp_count   = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pcie_mwr_pattern_gen.sv
// Directed bench for pcie_mwr_pattern_gen: streams, stalls, 4 KB split,
// 4DW header, abort and illegal configurations.
module tb_pcie_mwr_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cfg_addr = '0;
    logic [23:0] cfg_len = '0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        busy, done, err;
    logic [31:0] tlp_count, stall_count;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          d0;
    logic [15:0] exp_pat;
    logic [7:0]  exp_tag;

    pcie_mwr_pattern_gen_if txif();

    pcie_mwr_pattern_gen dut (
        .coreclkout_hip (clk),
        .reset_status   (rst),
        .cfg_addr       (cfg_addr),
        .cfg_len        (cfg_len),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .tx             (txif),
        .tlp_count      (tlp_count),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && done) done_cnt++;

    task automatic chk(input string tag, input logic [263:0] obs,
                       input logic [263:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_hdr(input logic [63:0] a,
                                             input int n,
                                             input logic [7:0] t);
        logic [127:0] h;
        logic [31:0]  ldw;
        ldw = 32'(n / 4) & 32'h3FF;
        if (a[63:32] != 32'd0)
            h = {a[31:0], a[63:32], 16'h0000, t, 8'hFF,
                 32'h6000_0000 | ldw};
        else
            h = {32'd0, a[31:2], 2'b00, 16'h0000, t, 8'hFF,
                 32'h4000_0000 | ldw};
        return h;
    endfunction

    task automatic start_job(input logic [63:0] a, input logic [23:0] l,
                             input bit ab);
        @(negedge clk);
        cfg_addr  = a;
        cfg_len   = l;
        cfg_start = 1'b1;
        cfg_abort = ab;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (txif.tx_valid) seen = 1'b1;
        end
        chk(tag, 264'(seen), 264'(1'b0));
    endtask

    task automatic run_tlp(input logic [63:0] a, input int n,
                           input bit rnd, input bit abt);
        int           beats, b, cyc, bytes, ab;
        bit           hold, rdy, last;
        logic [259:0] held;
        logic [255:0] ep, mask;
        beats = (n == 16) ? 1 : 1 + (n - 16 + 31) / 32;
        b = 0; cyc = 0; ab = 0; hold = 1'b0; held = '0;
        while (b < beats && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (ab == 1) begin cfg_abort = 1'b0; ab = 2; end
            if (abt && b == 1 && ab == 0) begin
                cfg_abort = 1'b1;
                ab = 1;
            end
            if (hold) begin
                chk("hold_valid", 264'(txif.tx_valid), 264'(1'b1));
                chk("hold_beat", 264'({txif.tx_sop, txif.tx_eop,
                    txif.tx_empty, txif.tx_data}), 264'(held));
            end
            rdy = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
            txif.tx_ready = rdy;
            hold = txif.tx_valid && !rdy;
            held = {txif.tx_sop, txif.tx_eop, txif.tx_empty, txif.tx_data};
            if (txif.tx_valid && rdy) begin
                last = (b == beats - 1);
                ep = '0; mask = '0; bytes = 32;
                if (b == 0) begin
                    chk("sop", 264'(txif.tx_sop), 264'(1'b1));
                    chk("hdr", 264'(txif.tx_data[127:0]),
                        264'(exp_hdr(a, n, exp_tag)));
                    for (int i = 0; i < 8; i++) begin
                        ep[128 + i*16 +: 16]   = exp_pat + 16'(i);
                        mask[128 + i*16 +: 16] = 16'hFFFF;
                    end
                    exp_pat = exp_pat + 16'd8;
                end else begin
                    chk("sop", 264'(txif.tx_sop), 264'(1'b0));
                    if (last && ((n - 16) % 32 == 16)) bytes = 16;
                    for (int i = 0; i < bytes / 2; i++) begin
                        ep[i*16 +: 16]   = exp_pat + 16'(i);
                        mask[i*16 +: 16] = 16'hFFFF;
                    end
                    exp_pat = exp_pat + 16'(bytes / 2);
                end
                chk("payload", 264'(txif.tx_data & mask), 264'(ep));
                chk("eop", 264'(txif.tx_eop), 264'(last));
                if (last)
                    chk("empty", 264'(txif.tx_empty),
                        264'((32 - bytes) / 8));
                b++;
            end
        end
        cfg_abort = 1'b0;
        chk("tlp_complete", 264'(b), 264'(beats));
        exp_tag = exp_tag + 8'd1;
    endtask

    initial begin
        txif.tx_ready = 1'b0;
        exp_pat = 16'h0000;
        exp_tag = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 264'(busy), 264'(1'b0));
        chk("rst_done", 264'(done), 264'(1'b0));
        chk("rst_err", 264'(err), 264'(1'b0));
        chk("rst_valid", 264'(txif.tx_valid), 264'(1'b0));
        chk("rst_flags", 264'({txif.tx_sop, txif.tx_eop,
            txif.tx_empty}), 264'(4'd0));
        chk("rst_data", 264'(txif.tx_data), 264'(256'd0));
        chk("rst_cnts", 264'({tlp_count, stall_count}), 264'(64'd0));
        rst = 1'b0;
        txif.tx_ready = 1'b1;

        // 16 KB job at full rate: 64 x 256 B TLPs
        d0 = done_cnt;
        start_job(64'h3000_0000, 24'h4000, 1'b0);
        chk("busy_a", 264'(busy), 264'(1'b1));
        exp_pat = 16'h0000;
        for (int t = 0; t < 64; t++)
            run_tlp(64'h3000_0000 + 64'(t * 256), 256, 1'b0, 1'b0);
        quiet(8, "tail_a");
        chk("done_a", 264'(done_cnt), 264'(d0 + 1));
        chk("idle_a", 264'(busy), 264'(1'b0));

        // Same job with backpressure
        d0 = done_cnt;
        start_job(64'h3000_0000, 24'h4000, 1'b0);
        exp_pat = 16'h0000;
        for (int t = 0; t < 64; t++)
            run_tlp(64'h3000_0000 + 64'(t * 256), 256, 1'b1, 1'b0);
        txif.tx_ready = 1'b1;
        quiet(8, "tail_b");
        chk("done_b", 264'(done_cnt), 264'(d0 + 1));
`ifdef PCIE_MWR_GEN_STATS_EN
        chk("tlp_count", 264'(tlp_count), 264'(32'd128));
        chk("stall_nz", 264'(stall_count != 32'd0), 264'(1'b1));
`else
        chk("tlp_count_off", 264'(tlp_count), 264'(32'd0));
        chk("stall_off", 264'(stall_count), 264'(32'd0));
`endif

        // 4 KB boundary split
        d0 = done_cnt;
        start_job(64'h0FC0, 24'h100, 1'b0);
        exp_pat = 16'h0000;
        run_tlp(64'h0FC0, 64, 1'b0, 1'b0);
        run_tlp(64'h1000, 192, 1'b0, 1'b0);
        quiet(8, "tail_c");
        chk("done_c", 264'(done_cnt), 264'(d0 + 1));

        // Single-beat 4DW TLP
        d0 = done_cnt;
        start_job(64'h1_0000_0000, 24'h10, 1'b0);
        exp_pat = 16'h0000;
        run_tlp(64'h1_0000_0000, 16, 1'b0, 1'b0);
        quiet(8, "tail_d");
        chk("done_d", 264'(done_cnt), 264'(d0 + 1));

        // Abort during third TLP
        d0 = done_cnt;
        start_job(64'h3000_0000, 24'h4000, 1'b0);
        exp_pat = 16'h0000;
        run_tlp(64'h3000_0000, 256, 1'b0, 1'b0);
        run_tlp(64'h3000_0100, 256, 1'b0, 1'b0);
        run_tlp(64'h3000_0200, 256, 1'b0, 1'b1);
        quiet(20, "abort_no_more");
        chk("done_abort", 264'(done_cnt), 264'(d0 + 1));
        chk("idle_abort", 264'(busy), 264'(1'b0));
        d0 = done_cnt;
        start_job(64'h2000, 24'h20, 1'b0);
        exp_pat = 16'h0000;
        run_tlp(64'h2000, 32, 1'b0, 1'b0);
        quiet(8, "tail_restart");
        chk("done_restart", 264'(done_cnt), 264'(d0 + 1));

        // Illegal configurations
        d0 = done_cnt;
        start_job(64'h0, 24'h18, 1'b0);
        chk("err_len", 264'(err), 264'(1'b1));
        chk("done_len", 264'(done), 264'(1'b1));
        quiet(5, "quiet_len");
        chk("idle_len", 264'(busy), 264'(1'b0));
        start_job(64'h4, 24'h10, 1'b0);
        chk("err_addr", 264'(err), 264'(1'b1));
        quiet(5, "quiet_addr");
        start_job(64'h100, 24'h0, 1'b0);
        chk("err_zero", 264'(err), 264'(1'b1));
        quiet(5, "quiet_zero");
        chk("done_bad", 264'(done_cnt), 264'(d0 + 3));

        // Legal start with simultaneous abort: start wins, err clears
        d0 = done_cnt;
        start_job(64'h0, 24'h10, 1'b1);
        chk("err_clear", 264'(err), 264'(1'b0));
        chk("busy_f", 264'(busy), 264'(1'b1));
        exp_pat = 16'h0000;
        run_tlp(64'h0, 16, 1'b0, 1'b0);
        quiet(8, "tail_f");
        chk("done_f", 264'(done_cnt), 264'(d0 + 1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_mwr_pattern_gen.md
Name: pcie_mwr_pattern_gen

Overview:
Parametrised DMA write engine for the PCIe endpoint TX path. Once a host-programmed job is started, it emits Memory Write TLPs on the 256-bit Avalon-ST TX interface. The payload is a continuous incrementing 16-bit pattern. It generalises the fixed-size 3DW generator: configurable max payload, 64-bit addressing with automatic 3DW/4DW header selection, 4 KB boundary splitting, tag sequencing and graceful abort. It sits between the BAR2 register file (config/start) and the TX arbiter.

Parameters:
MAX_PAYLOAD, 256, max TLP payload in bytes; legal values 128, 256, 512
REQ_ID, 16'h0000, Requester ID placed in every header
PATTERN_INIT, 16'h0000, first pattern value after start
MAX_LEN_W, 24, width of the byte-length config field

Ports:
coreclkout_hip  in  1  clock
reset_status  in  1  asynchronous active-high reset
cfg_addr  in  64  job start address in bytes; bits[3:0] must be 0
cfg_len  in  MAX_LEN_W  job length in bytes; must be a nonzero multiple of 16
cfg_start  in  1  one-cycle pulse; latches cfg_* while idle
cfg_abort  in  1  pulse; stop after the current TLP completes
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end (normal or aborted)
err  out  1  sticky illegal-config flag; cleared by the next legal start
tx_data  out  256  TLP beat
tx_valid  out  1  beat valid
tx_ready  in  1  sink ready; ready latency 0
tx_sop  out  1  first beat of TLP
tx_eop  out  1  last beat of TLP
tx_empty  out  2  empty 64-bit words on the eop beat
tlp_count  out  32  TLPs sent since reset (PCIE_MWR_GEN_STATS_EN only)
stall_count  out  32  cycles with valid && !ready (PCIE_MWR_GEN_STATS_EN only)

Behaviour:
- Reset (async, reset_status=1): all outputs 0, state IDLE, tag 0, pattern = PATTERN_INIT.
- Transfer rule: a beat moves when tx_valid && tx_ready. While tx_valid=1, tx_data, tx_sop, tx_eop and tx_empty are held stable until the beat is accepted. tx_valid is never withdrawn.
- FSM states:
  - IDLE: on cfg_start, check the config.
    - Illegal (len==0, len[3:0]!=0, addr[3:0]!=0): set err, pulse done next cycle, stay IDLE.
    - Legal: clear err, latch addr/len, set pattern = PATTERN_INIT, go to CALC.
  - CALC: compute n = min(remaining, MAX_PAYLOAD, 4096 - addr[11:0]). Takes 1 cycle. Go to HDR.
  - HDR: present the header beat with sop=1.
    - If n==16: eop=1, empty=0, and on acceptance go to NEXT.
    - Otherwise go to DATA on acceptance.
  - DATA: 32 payload bytes per beat.
    - Last beat: eop=1, empty = (32 - bytes_in_beat)/8, i.e. 0 or 2.
    - On eop acceptance go to NEXT.
  - NEXT: addr += n, remaining -= n, tag++.
    - If remaining==0 or an abort is pending: pulse done, go to IDLE.
    - Otherwise go to CALC.
- Header beat layout:
  - bits[127:0] hold the header, DW0 in [31:0].
  - Fmt = 3'b010 (3DW) if addr[63:32]==0, else 3'b011 (4DW). Type 0, TC/attr 0.
  - Length = n/4 DW, with 1024 DW encoded as 0. FirstBE = LastBE = 4'hF. Tag 8-bit, wraps 255 -> 0.
  - 3DW: DW2 = addr[31:2]<<2, DW3 = 0 (pad).
  - 4DW: DW2 = addr[63:32], DW3 = addr[31:0].
  - bits[255:128] carry the first 16 payload bytes.
- Pattern:
  - 16-bit little-endian words, lowest byte lane first, +1 per word.
  - Wraps 0xFFFF -> 0x0000.
  - Continuous across TLPs within a job.
- Abort:
  - cfg_abort sets a pending flag and never truncates a TLP.
  - In CALC it takes effect before the header is issued: go to NEXT-exit with no TLP.
  - Ignored while IDLE.
- cfg_start while busy: ignored.
- Simultaneous cfg_start and cfg_abort in IDLE: start wins, abort ignored.
- busy = (state != IDLE).

Optional Feature:
PCIE_MWR_GEN_STATS_EN:
- Defined: tlp_count increments on each accepted eop beat; stall_count increments each cycle with tx_valid && !tx_ready. Both are 32-bit saturating, cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- addr 0x3000_0000, len 0x4000, MAX_PAYLOAD 256, ready 100% -> 64 TLPs; each 3DW, Length 64, 9 beats, last beat empty=2; tags 0..63; pattern 0x0000..0x1FFF continuous; one done pulse.
- Same job with 70% random ready -> identical TLP stream, no gaps in the pattern, data held stable while stalled; stall_count > 0 when stats enabled.
- addr 0x0FC0, len 0x100 -> TLP1 64 B at 0xFC0 (Length 16), TLP2 192 B at 0x1000 (Length 48); no TLP crosses 4 KB.
- addr 0x1_0000_0000, len 16 -> single-beat 4DW TLP: Fmt 3'b011, DW2=0x1, DW3=0x0, sop=eop=1, empty=0.
- len 0x4000 with cfg_abort after the 3rd TLP's sop -> exactly 3 complete TLPs, then done; next start restarts the pattern at PATTERN_INIT.
- len 0x18 or addr 0x4 -> err=1, done pulse, no tx_valid; a following legal start clears err.
